// File: rtl/exe_stage_if.sv
// Valid/allowin pipeline handshake between adjacent core stages.
// The master drives valid and bus; the slave answers with allowin.
interface exe_stage_if #(
  parameter int W = 1
);
  logic         valid;
  logic         allowin;
  logic [W-1:0] bus;

  modport master (
    output valid,
    output bus,
    input  allowin
  );

  modport slave (
    input  valid,
    input  bus,
    output allowin
  );
endinterface

// File: rtl/exe_stage.sv
// EXE stage of the LA32R core: latches decode output, runs the ALU,
// issues data SRAM requests and forwards results to MEM and decode.
module exe_stage #(
  parameter int DS2ES_LEN = 148,
  parameter int ES2MS_LEN = 71
) (
  input  logic        clk,
  input  logic        reset,
  exe_stage_if.slave  ds,
  exe_stage_if.master ms,
  output logic [38:0] es_rf_zip,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic                 r_es_valid;
  logic [DS2ES_LEN-1:0] r_payload;

  logic        w_ready_go;
  logic        w_allowin;
  logic [11:0] w_alu_op;
  logic        w_res_from_mem;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic        w_mem_we;
  logic        w_rf_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_rkd;
  logic [31:0] w_pc;
  logic [4:0]  w_shamt;
  logic [31:0] w_alu_result;
  logic        w_rf_we_vld;
  logic        w_to_mem;

  assign {w_alu_op, w_res_from_mem, w_src1, w_src2,
          w_mem_we, w_rf_we, w_waddr, w_rkd, w_pc} = r_payload;

  assign w_ready_go = 1'b1;
  assign w_allowin  = ~r_es_valid | (w_ready_go & ms.allowin);
  assign ds.allowin = w_allowin;
  assign ms.valid   = r_es_valid & w_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
      r_payload  <= '0;
    end else begin
      if (w_allowin)
        r_es_valid <= ds.valid;
      if (ds.valid & w_allowin)
        r_payload <= ds.bus;
    end
  end

  assign w_shamt = w_src2[4:0];

  always_comb begin
    w_alu_result = '0;
    unique case (1'b1)
      w_alu_op[0]:  w_alu_result = w_src1 + w_src2;
      w_alu_op[1]:  w_alu_result = w_src1 - w_src2;
      w_alu_op[2]:  w_alu_result = {31'd0, $signed(w_src1) < $signed(w_src2)};
      w_alu_op[3]:  w_alu_result = {31'd0, w_src1 < w_src2};
      w_alu_op[4]:  w_alu_result = w_src1 & w_src2;
      w_alu_op[5]:  w_alu_result = ~(w_src1 | w_src2);
      w_alu_op[6]:  w_alu_result = w_src1 | w_src2;
      w_alu_op[7]:  w_alu_result = w_src1 ^ w_src2;
      w_alu_op[8]:  w_alu_result = w_src1 << w_shamt;
      w_alu_op[9]:  w_alu_result = w_src1 >> w_shamt;
      w_alu_op[10]: w_alu_result = $signed(w_src1) >>> w_shamt;
      w_alu_op[11]: w_alu_result = w_src2;
      default:      w_alu_result = '0;
    endcase
  end

  // Gate rf_we so a stale payload never looks like a live write.
  assign w_rf_we_vld = w_rf_we & r_es_valid;

  // SRAM request fires only on the cycle the instruction moves to MEM.
  assign w_to_mem        = r_es_valid & ms.allowin;
  assign data_sram_en    = w_to_mem & (w_res_from_mem | w_mem_we);
  assign data_sram_we    = {4{w_to_mem & w_mem_we}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = w_rkd;

  assign es_rf_zip = {w_res_from_mem, w_rf_we_vld, w_waddr, w_alu_result};
  assign ms.bus    = ES2MS_LEN'({w_res_from_mem, w_rf_we_vld, w_waddr,
                                 w_alu_result, w_pc});

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU vector table plus handshake,
// store, load-bypass and asynchronous reset sequences.
module tb_exe_stage;

  logic        clk;
  logic        reset;
  logic [38:0] es_rf_zip;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  exe_stage_if #(.W(148)) ds_if ();
  exe_stage_if #(.W(71))  ms_if ();

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds              (ds_if),
    .ms              (ms_if),
    .es_rf_zip       (es_rf_zip),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];

  // Instructions seen leaving to MEM (inputs are stable from negedge to posedge).
  always @(negedge clk)
    if (!reset && ms_if.valid && ms_if.allowin)
      q.push_back(ms_if.bus[31:0]);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [147:0] mk(
    input logic [11:0] op, input logic rfm,
    input logic [31:0] s1, input logic [31:0] s2,
    input logic mwe, input logic rfwe, input logic [4:0] wa,
    input logic [31:0] rkd, input logic [31:0] pc);
    return {op, rfm, s1, s2, mwe, rfwe, wa, rkd, pc};
  endfunction

  typedef struct {
    string       name;
    logic [11:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{"add",   12'h001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    tbl[1]  = '{"sub",   12'h002, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    tbl[2]  = '{"slt1",  12'h004, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    tbl[3]  = '{"slt0",  12'h004, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    tbl[4]  = '{"sltu",  12'h008, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    tbl[5]  = '{"and",   12'h010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    tbl[6]  = '{"nor",   12'h020, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    tbl[7]  = '{"or",    12'h040, 32'h00FF0000, 32'h000000FF, 32'h00FF00FF};
    tbl[8]  = '{"xor",   12'h080, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555};
    tbl[9]  = '{"sll31", 12'h100, 32'h00000001, 32'h0000001F, 32'h80000000};
    tbl[10] = '{"sllmsk",12'h100, 32'h00000001, 32'h00000021, 32'h00000002};
    tbl[11] = '{"srl",   12'h200, 32'h80000000, 32'h00000004, 32'h08000000};
    tbl[12] = '{"sra",   12'h400, 32'h80000000, 32'h00000004, 32'hF8000000};
    tbl[13] = '{"lui",   12'h800, 32'hFFFFFFFF, 32'h12345000, 32'h12345000};
    tbl[14] = '{"noop",  12'h000, 32'h12345678, 32'h11111111, 32'h00000000};

    reset = 1'b1;
    ds_if.valid = 1'b0;
    ds_if.bus = '0;
    ms_if.allowin = 1'b0;
    #1;
    chk("rst_valid", 64'(ms_if.valid), 64'd0);
    chk("rst_allowin", 64'(ds_if.allowin), 64'd1);
    chk("rst_zip", 64'(es_rf_zip), 64'd0);
    chk("rst_en", 64'(data_sram_en), 64'd0);
    chk("rst_we", 64'(data_sram_we), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_allowin", 64'(ds_if.allowin), 64'd1);
    chk("post_rst_valid", 64'(ms_if.valid), 64'd0);

    // ALU table, streamed back to back.
    ms_if.allowin = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ds_if.bus = mk(tbl[i].op, 1'b0, tbl[i].s1, tbl[i].s2, 1'b0, 1'b1,
                     5'd5, 32'd0, 32'(i * 4));
      ds_if.valid = 1'b1;
      step();
      chk({tbl[i].name, "_valid"}, 64'(ms_if.valid), 64'd1);
      chk({tbl[i].name, "_res"}, 64'(ms_if.bus[63:32]), 64'(tbl[i].exp));
      chk({tbl[i].name, "_zip"}, 64'(es_rf_zip),
          64'({1'b0, 1'b1, 5'd5, tbl[i].exp}));
      chk({tbl[i].name, "_pc"}, 64'(ms_if.bus[31:0]), 64'(i * 4));
      chk({tbl[i].name, "_en"}, 64'(data_sram_en), 64'd0);
    end
    ds_if.valid = 1'b0;
    step();
    chk("drain_valid", 64'(ms_if.valid), 64'd0);
    chk("drain_zip_we", 64'(es_rf_zip[37]), 64'd0);

    // Store held by MEM back-pressure.
    ms_if.allowin = 1'b0;
    ds_if.bus = mk(12'h001, 1'b0, 32'h1000, 32'h8, 1'b1, 1'b0,
                   5'd0, 32'hDEADBEEF, 32'h200);
    ds_if.valid = 1'b1;
    step();
    ds_if.valid = 1'b0;
    chk("st_stall1_en", 64'(data_sram_en), 64'd0);
    chk("st_stall1_we", 64'(data_sram_we), 64'd0);
    chk("st_stall_allowin", 64'(ds_if.allowin), 64'd0);
    step();
    chk("st_stall2_en", 64'(data_sram_en), 64'd0);
    chk("st_stall2_we", 64'(data_sram_we), 64'd0);
    ms_if.allowin = 1'b1;
    #1;
    chk("st_en", 64'(data_sram_en), 64'd1);
    chk("st_we", 64'(data_sram_we), 64'hF);
    chk("st_addr", 64'(data_sram_addr), 64'h1008);
    chk("st_wdata", 64'(data_sram_wdata), 64'hDEADBEEF);
    step();
    chk("st_after_en", 64'(data_sram_en), 64'd0);
    chk("st_after_we", 64'(data_sram_we), 64'd0);
    chk("st_after_valid", 64'(ms_if.valid), 64'd0);

    // Three instructions against a stalled MEM.
    q.delete();
    ms_if.allowin = 1'b0;
    ds_if.bus = mk(12'h001, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1, 5'd1, 0, 32'hA0);
    ds_if.valid = 1'b1;
    step();
    ds_if.bus = mk(12'h001, 1'b0, 32'd2, 32'd2, 1'b0, 1'b1, 5'd2, 0, 32'hB0);
    chk("bp_allowin0", 64'(ds_if.allowin), 64'd0);
    step();
    chk("bp_hold_pc1", 64'(ms_if.bus[31:0]), 64'hA0);
    chk("bp_hold_res1", 64'(ms_if.bus[63:32]), 64'd2);
    step();
    chk("bp_hold_pc2", 64'(ms_if.bus[31:0]), 64'hA0);
    chk("bp_allowin1", 64'(ds_if.allowin), 64'd0);
    ms_if.allowin = 1'b1;
    #1;
    chk("bp_release_allowin", 64'(ds_if.allowin), 64'd1);
    step();
    chk("bp_pc_b", 64'(ms_if.bus[31:0]), 64'hB0);
    ds_if.bus = mk(12'h001, 1'b0, 32'd3, 32'd3, 1'b0, 1'b1, 5'd3, 0, 32'hC0);
    step();
    chk("bp_pc_c", 64'(ms_if.bus[31:0]), 64'hC0);
    chk("bp_res_c", 64'(ms_if.bus[63:32]), 64'd6);
    ds_if.valid = 1'b0;
    step();
    chk("bp_empty", 64'(ms_if.valid), 64'd0);
    chk("bp_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("bp_order0", 64'(q[0]), 64'hA0);
      chk("bp_order1", 64'(q[1]), 64'hB0);
      chk("bp_order2", 64'(q[2]), 64'hC0);
    end

    // Load forwarding info to decode.
    ms_if.allowin = 1'b0;
    ds_if.bus = mk(12'h001, 1'b1, 32'h40, 32'h4, 1'b0, 1'b1, 5'd7, 0, 32'h300);
    ds_if.valid = 1'b1;
    step();
    ds_if.valid = 1'b0;
    chk("ld_zip_rfm", 64'(es_rf_zip[38]), 64'd1);
    chk("ld_zip_we", 64'(es_rf_zip[37]), 64'd1);
    chk("ld_zip_wa", 64'(es_rf_zip[36:32]), 64'd7);
    chk("ld_stall_en", 64'(data_sram_en), 64'd0);
    ms_if.allowin = 1'b1;
    #1;
    chk("ld_en", 64'(data_sram_en), 64'd1);
    chk("ld_we", 64'(data_sram_we), 64'd0);
    chk("ld_addr", 64'(data_sram_addr), 64'h44);
    step();
    chk("ld_gone_zip_we", 64'(es_rf_zip[37]), 64'd0);
    chk("ld_gone_en", 64'(data_sram_en), 64'd0);

    // Asynchronous reset with a store in flight.
    ds_if.bus = mk(12'h001, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 5'd9, 32'h55, 32'h400);
    ds_if.valid = 1'b1;
    step();
    ds_if.valid = 1'b0;
    chk("ar_pre_en", 64'(data_sram_en), 64'd1);
    chk("ar_pre_valid", 64'(ms_if.valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(ms_if.valid), 64'd0);
    chk("ar_en", 64'(data_sram_en), 64'd0);
    chk("ar_we", 64'(data_sram_we), 64'd0);
    chk("ar_zip_we", 64'(es_rf_zip[37]), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("ar_after_allowin", 64'(ds_if.allowin), 64'd1);
    chk("ar_after_valid", 64'(ms_if.valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
